// File: rtl/bist_pkg.sv
// Shared constants for the full-adder BIST chain: FSM states, MISR geometry,
// default seed/golden signature and session length.
package bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COMPACT,
    ST_COMPARE,
    ST_DONE
  } state_e;

  localparam int MISR_W = 4;
  // Bit positions that receive the s3 feedback (n0 and n1).
  localparam logic [MISR_W-1:0] MISR_FB_TAPS = 4'b0011;
  localparam logic [MISR_W-1:0] DEF_SEED     = 4'h0;
  localparam logic [MISR_W-1:0] DEF_GOLDEN   = 4'hB;
  localparam int DEF_PAT_CNT = 8;

  function automatic logic [MISR_W-1:0] misr_next(input logic [MISR_W-1:0] s,
                                                  input logic [1:0]        d);
    logic [MISR_W-1:0] fb;
    fb = s[MISR_W-1] ? MISR_FB_TAPS : '0;
    return {s[MISR_W-2:0], 1'b0} ^ fb ^ {{(MISR_W-2){1'b0}}, d};
  endfunction

endpackage

// File: rtl/bist_misr.sv
// 4-bit multiple-input signature register with synchronous seed load and
// shift enable; load has priority over shift.
module bist_misr
  import bist_pkg::*;
#(
  parameter int                SIG_W = MISR_W,
  parameter logic [SIG_W-1:0]  SEED  = DEF_SEED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [1:0]       d,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    if (load) begin
      sig_d = SEED;
    end else if (shift) begin
      sig_d = misr_next(sig_q, d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/bist_ora.sv
// Output response analyser: compacts PAT_CNT sum/cout responses into a MISR
// and compares the final signature against GOLDEN.
module bist_ora
  import bist_pkg::*;
#(
  parameter int               SIG_W   = MISR_W,
  parameter int               PAT_CNT = DEF_PAT_CNT,
  parameter logic [SIG_W-1:0] SEED    = DEF_SEED,
  parameter logic [SIG_W-1:0] GOLDEN  = DEF_GOLDEN
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         in_valid,
  input  logic                         sum,
  input  logic                         cout,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic                         fail,
  output logic [SIG_W-1:0]             signature,
  output logic [$clog2(PAT_CNT+1)-1:0] resp_cnt
);

  localparam int CNT_W = $clog2(PAT_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(PAT_CNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAT_CNT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             misr_load;
  logic             misr_shift;
  logic [SIG_W-1:0] sig;

  bist_misr #(
    .SIG_W (SIG_W),
    .SEED  (SEED)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (misr_load),
    .shift (misr_shift),
    .d     ({cout, sum}),
    .sig   (sig)
  );

  // start in IDLE/DONE wins over a coincident in_valid; start elsewhere is ignored.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    misr_load  = 1'b0;
    misr_shift = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          misr_load = 1'b1;
          cnt_d     = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          fail_d    = 1'b0;
          state_d   = ST_COMPACT;
        end
      end
      ST_COMPACT: begin
        if (in_valid) begin
          misr_shift = 1'b1;
          cnt_d      = (cnt_q < CNT_MAX) ? cnt_q + 1'b1 : cnt_q;
          if (cnt_q == CNT_LAST) begin
            state_d = ST_COMPARE;
          end
        end
      end
      ST_COMPARE: begin
        pass_d  = (sig == GOLDEN);
        fail_d  = (sig != GOLDEN);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign signature = sig;
  assign resp_cnt  = cnt_q;

endmodule

// File: tb/tb_bist_ora.sv
// Directed self-checking bench for bist_ora: a full-adder CUT model with
// optional faults feeds the ORA, and a scoreboard tracks expected signatures.
module tb_bist_ora;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic       sum;
  logic       cout;
  logic       busy;
  logic       done;
  logic       pass;
  logic       fail;
  logic [3:0] signature;
  logic [3:0] resp_cnt;

  typedef struct packed {
    logic [3:0] sig;
    logic [3:0] cnt;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] model_sig;
  logic [3:0] model_cnt;
  int         tests_run;
  int         tests_failed;

  localparam int FAULT_NONE = 0;
  localparam int FAULT_A_SA0 = 1;
  localparam int FAULT_SUM_SA1 = 2;

  bist_ora #(
    .SIG_W   (4),
    .PAT_CNT (8),
    .SEED    (4'h0),
    .GOLDEN  (4'hB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail      (fail),
    .signature (signature),
    .resp_cnt  (resp_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference MISR written directly from the update equations.
  function automatic logic [3:0] ref_misr(input logic [3:0] s, input logic d1, input logic d0);
    logic [3:0] n;
    n[0] = s[3] ^ d0;
    n[1] = s[0] ^ s[3] ^ d1;
    n[2] = s[1];
    n[3] = s[2];
    return n;
  endfunction

  task automatic cut_model(input int p, input int fault, output logic s, output logic c);
    logic a, b, ci;
    a  = p[2];
    b  = p[1];
    ci = p[0];
    if (fault == FAULT_A_SA0) a = 1'b0;
    s = a ^ b ^ ci;
    c = (a & b) | (a & ci) | (b & ci);
    if (fault == FAULT_SUM_SA1) s = 1'b1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic vld, input logic s, input logic c);
    start    = st;
    in_valid = vld;
    sum      = s;
    cout     = c;
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic drive_response(input int p, input int fault, input logic st);
    logic s, c;
    exp_t e;
    cut_model(p, fault, s, c);
    model_sig = ref_misr(model_sig, c, s);
    model_cnt = model_cnt + 4'd1;
    exp_q.push_back('{sig: model_sig, cnt: model_cnt});
    applyStimulus(st, 1'b1, s, c);
    if (exp_q.size() == 0) begin
      checkOutput("scoreboard_empty", 8'd1, 8'd0);
    end else begin
      e = exp_q.pop_front();
      checkOutput($sformatf("sig_p%0d", p), {4'h0, signature}, {4'h0, e.sig});
      checkOutput($sformatf("cnt_p%0d", p), {4'h0, resp_cnt}, {4'h0, e.cnt});
    end
  endtask

  task automatic begin_session(input logic with_valid);
    applyStimulus(1'b1, with_valid, 1'b1, 1'b1);
    model_sig = 4'h0;
    model_cnt = 4'h0;
    checkOutput("start_busy", {7'd0, busy}, 8'd1);
    checkOutput("start_sig", {4'h0, signature}, 8'h0);
    checkOutput("start_cnt", {4'h0, resp_cnt}, 8'd0);
    checkOutput("start_flags", {5'd0, done, pass, fail}, 8'd0);
  endtask

  task automatic run_session(input int fault, input logic gaps, input logic mid_start,
                             input logic [3:0] golden_sig, input logic exp_pass);
    for (int p = 0; p < 8; p++) begin
      if (gaps) begin
        applyStimulus(1'b0, 1'b0, p[0], p[1]);
        checkOutput("gap_cnt", {4'h0, resp_cnt}, {4'h0, model_cnt});
        checkOutput("gap_sig", {4'h0, signature}, {4'h0, model_sig});
      end
      drive_response(p, fault, mid_start && (p == 3));
    end
    checkOutput("compare_done", {7'd0, done}, 8'd0);
    checkOutput("compare_busy", {7'd0, busy}, 8'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("final_done", {7'd0, done}, 8'd1);
    checkOutput("final_busy", {7'd0, busy}, 8'd0);
    checkOutput("final_sig", {4'h0, signature}, {4'h0, golden_sig});
    checkOutput("final_pass", {7'd0, pass}, {7'd0, exp_pass});
    checkOutput("final_fail", {7'd0, fail}, {7'd0, !exp_pass});
    checkOutput("final_cnt", {4'h0, resp_cnt}, 8'd8);
  endtask

  initial begin
    clk          = 1'b0;
    rst_n        = 1'b0;
    start        = 1'b0;
    in_valid     = 1'b0;
    sum          = 1'b0;
    cout         = 1'b0;
    tests_run    = 0;
    tests_failed = 0;
    model_sig    = 4'h0;
    model_cnt    = 4'h0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_sig", {4'h0, signature}, 8'h0);
    checkOutput("reset_cnt", {4'h0, resp_cnt}, 8'd0);
    checkOutput("reset_flags", {4'd0, busy, done, pass, fail}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // in_valid while idle must not touch the MISR
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("idle_valid_sig", {4'h0, signature}, 8'h0);
    checkOutput("idle_valid_cnt", {4'h0, resp_cnt}, 8'd0);

    $display("[TB] fault-free, continuous");
    begin_session(1'b0);
    run_session(FAULT_NONE, 1'b0, 1'b0, 4'hB, 1'b1);

    // in_valid while done is ignored and results hold
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("done_hold_sig", {4'h0, signature}, 8'hB);
    checkOutput("done_hold_flags", {5'd0, done, pass, fail}, 8'b110);

    $display("[TB] a stuck-at-0");
    begin_session(1'b0);
    run_session(FAULT_A_SA0, 1'b0, 1'b0, 4'h8, 1'b0);

    $display("[TB] sum stuck-at-1");
    begin_session(1'b0);
    run_session(FAULT_SUM_SA1, 1'b0, 1'b0, 4'h5, 1'b0);

    $display("[TB] fault-free with gaps");
    begin_session(1'b0);
    run_session(FAULT_NONE, 1'b1, 1'b0, 4'hB, 1'b1);

    $display("[TB] start pulsed mid-session");
    begin_session(1'b0);
    run_session(FAULT_NONE, 1'b0, 1'b1, 4'hB, 1'b1);

    $display("[TB] reset mid-session");
    begin_session(1'b0);
    for (int p = 0; p < 4; p++) drive_response(p, FAULT_NONE, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_sig", {4'h0, signature}, 8'h0);
    checkOutput("async_rst_cnt", {4'h0, resp_cnt}, 8'd0);
    checkOutput("async_rst_flags", {4'd0, busy, done, pass, fail}, 8'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    begin_session(1'b0);
    run_session(FAULT_NONE, 1'b0, 1'b0, 4'hB, 1'b1);

    $display("[TB] back-to-back restart from done with coincident in_valid");
    begin_session(1'b1);
    run_session(FAULT_NONE, 1'b0, 1'b0, 4'hB, 1'b1);

    checkOutput("scoreboard_drained", 8'(exp_q.size()), 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
